// File: rtl/led_display_arbiter.sv
// led_display_arbiter: round-robin owner selection for the shared 12-position
// bicolour LED display. It enforces a minimum hold time, preempts an owner at
// the end of its time slice only when another source is waiting, and inserts a
// blanking gap before the display passes to the next owner.
module led_display_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned DIV      = 20,
  parameter int unsigned MIN_HOLD = 2,
  parameter int unsigned SLICE    = 8,
  parameter int unsigned BLANK    = 1024
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*12-1:0] req_yr,
  input  logic [N_REQ*12-1:0] req_bg,
  output logic [N_REQ-1:0]    grant,
  output logic [11:0]         led_in_yr,
  output logic [11:0]         led_in_bg,
  output logic                busy
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned HW = $clog2(SLICE + 1);
  localparam int unsigned BW = $clog2(BLANK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_BLANK
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV-1:0]   div_ctr;
  logic             tick;
  logic [HW-1:0]    hold_ctr;
  logic [BW-1:0]    blank_ctr;
  logic [OW-1:0]    last_owner;
  logic [OW-1:0]    winner;
  logic [OW-1:0]    scan_idx;
  logic             scan_found;
  logic [N_REQ-1:0] owner_mask;
  logic             others_waiting;
  logic             release_ok;
  logic             preempt_ok;
  logic             own_exit;
  logic             blank_done;
  logic             take_grant;

  // Decode of owner, exit conditions and prescaler tick.
  // last_owner doubles as the current owner while in S_OWN, so the one-hot
  // grant is derived from it rather than stored separately.
  always_comb begin
    tick           = &div_ctr;
    owner_mask     = N_REQ'(1) << last_owner;
    others_waiting = |(req & ~owner_mask);
    release_ok     = !req[last_owner] && (hold_ctr >= HW'(MIN_HOLD));
    preempt_ok     = others_waiting && (hold_ctr >= HW'(SLICE));
    own_exit       = release_ok || preempt_ok;
    blank_done     = (blank_ctr == BW'(BLANK - 1));
    take_grant     = (|req) && ((state == S_IDLE) || ((state == S_BLANK) && blank_done));
  end

  // Round-robin winner: first active request after the previous owner.
  always_comb begin
    winner     = last_owner;
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      scan_idx = OW'((32'(last_owner) + i) % N_REQ);
      if (!scan_found && req[scan_idx]) begin
        winner     = scan_idx;
        scan_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (|req) state_next = S_OWN;
      S_OWN:   if (own_exit) state_next = S_BLANK;
      S_BLANK: if (blank_done) state_next = (|req) ? S_OWN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy  = (state != S_IDLE);
    grant = (state == S_OWN) ? owner_mask : '0;
  end

  // Prescaler, hold/blank counters, owner tracking and registered LED planes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_ctr    <= '0;
      hold_ctr   <= '0;
      blank_ctr  <= '0;
      last_owner <= OW'(N_REQ - 1);
      led_in_yr  <= '0;
      led_in_bg  <= '0;
    end else begin
      div_ctr <= div_ctr + 1'b1;
      if (take_grant) begin
        last_owner <= winner;
        hold_ctr   <= '0;
      end
      case (state)
        S_OWN: begin
          if (own_exit) begin
            blank_ctr <= '0;
            led_in_yr <= '0;
            led_in_bg <= '0;
          end else begin
            // Pattern freezes while the owner has dropped its request.
            if (req[last_owner]) begin
              led_in_yr <= req_yr[32'(last_owner)*12 +: 12];
              led_in_bg <= req_bg[32'(last_owner)*12 +: 12];
            end
            if (tick && (hold_ctr < HW'(SLICE))) begin
              hold_ctr <= hold_ctr + 1'b1;
            end
          end
        end
        S_BLANK: begin
          blank_ctr <= blank_ctr + 1'b1;
          led_in_yr <= '0;
          led_in_bg <= '0;
        end
        default: begin
          led_in_yr <= '0;
          led_in_bg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_arbiter.sv
// Directed bench for led_display_arbiter with DIV=2 (tick every 4 clk),
// MIN_HOLD=2, SLICE=4, BLANK=3, N_REQ=4. Edge E0 is the first posedge after
// reset release; the prescaler is 0 there, so ticks land on E3, E7, E11, ...
module tb_led_display_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [47:0] req_yr;
  logic [47:0] req_bg;
  logic [3:0]  grant;
  logic [11:0] led_in_yr;
  logic [11:0] led_in_bg;
  logic        busy;

  int n_checks;
  int n_fail;
  int cyc;

  localparam logic [47:0] YR_INIT = {12'h4D4, 12'h3C3, 12'h2B2, 12'h1A1};
  localparam logic [47:0] BG_INIT = {12'h848, 12'h737, 12'h626, 12'h515};

  led_display_arbiter #(
    .N_REQ(4),
    .DIV(2),
    .MIN_HOLD(2),
    .SLICE(4),
    .BLANK(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .req(req),
    .req_yr(req_yr),
    .req_bg(req_bg),
    .grant(grant),
    .led_in_yr(led_in_yr),
    .led_in_bg(led_in_bg),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock edge, then settle; inputs change and outputs are sampled here.
  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) adv();
  endtask

  task automatic check_off(input string tag);
    check({tag, ".grant"}, 32'(grant), 32'h0);
    check({tag, ".yr"}, 32'(led_in_yr), 32'h0);
    check({tag, ".bg"}, 32'(led_in_bg), 32'h0);
  endtask

  // Two reset edges with the given request vector, then release.
  task automatic do_reset(input logic [3:0] req_during, input logic [3:0] req_after);
    resetn = 1'b0;
    req    = req_during;
    adv();
    adv();
    check_off("rst");
    check("rst.busy", 32'(busy), 32'h0);
    resetn = 1'b1;
    req    = req_after;
    cyc    = -1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    resetn   = 1'b0;
    req      = '0;
    req_yr   = YR_INIT;
    req_bg   = BG_INIT;

    // 1: reset with all requesting; source 0 wins first
    do_reset(4'b1111, 4'b1111);
    adv();
    check("t1.grant", 32'(grant), 32'h1);
    check("t1.yr_lat", 32'(led_in_yr), 32'h0);
    check("t1.busy", 32'(busy), 32'h1);
    adv();
    check("t1.yr", 32'(led_in_yr), 32'h1A1);
    check("t1.bg", 32'(led_in_bg), 32'h515);

    // 2: sole owner never released, live pattern update
    do_reset(4'b0000, 4'b0100);
    adv();
    check("t2.grant0", 32'(grant), 32'h4);
    adv();
    check("t2.yr", 32'(led_in_yr), 32'h3C3);
    check("t2.bg", 32'(led_in_bg), 32'h737);
    while (cyc < 100) begin
      if (cyc == 50) req_yr[35:24] = 12'hA5A;
      adv();
      check("t2.grant", 32'(grant), 32'h4);
      if (cyc == 51) check("t2.yr_new", 32'(led_in_yr), 32'hA5A);
    end
    check("t2.busy", 32'(busy), 32'h1);
    req_yr = YR_INIT;

    // 3: early drop keeps grant and frozen pattern until MIN_HOLD, then blank, idle
    do_reset(4'b0000, 4'b0001);
    adv();
    check("t3.grant", 32'(grant), 32'h1);
    adv();
    check("t3.yrA", 32'(led_in_yr), 32'h1A1);
    req_yr[11:0] = 12'h0B0;
    adv();
    check("t3.yrB", 32'(led_in_yr), 32'h0B0);
    req          = 4'b0000;
    req_yr[11:0] = 12'h0C0;
    run_to(5);
    check("t3.frozen", 32'(led_in_yr), 32'h0B0);
    check("t3.grant5", 32'(grant), 32'h1);
    run_to(7);
    check("t3.grant7", 32'(grant), 32'h1);
    adv();
    check_off("t3.blank");
    check("t3.busy8", 32'(busy), 32'h1);
    run_to(10);
    check("t3.busy10", 32'(busy), 32'h1);
    check("t3.grant10", 32'(grant), 32'h0);
    adv();
    check("t3.idle", 32'(busy), 32'h0);
    check("t3.grant11", 32'(grant), 32'h0);
    req_yr = YR_INIT;

    // 4: round-robin 0 -> 1 -> 3 -> 0 with 3-cycle gaps
    do_reset(4'b1011, 4'b1011);
    adv();
    check("t4.g0", 32'(grant), 32'h1);
    run_to(15);
    check("t4.g0_end", 32'(grant), 32'h1);
    adv();
    check_off("t4.gap0");
    check("t4.gap0_busy", 32'(busy), 32'h1);
    run_to(18);
    check_off("t4.gap0_end");
    adv();
    check("t4.g1", 32'(grant), 32'h2);
    adv();
    check("t4.g1_yr", 32'(led_in_yr), 32'h2B2);
    run_to(35);
    check("t4.g1_end", 32'(grant), 32'h2);
    adv();
    check("t4.gap1", 32'(grant), 32'h0);
    run_to(39);
    check("t4.g3", 32'(grant), 32'h8);
    adv();
    check("t4.g3_bg", 32'(led_in_bg), 32'h848);
    run_to(55);
    check("t4.g3_end", 32'(grant), 32'h8);
    run_to(59);
    check("t4.g0_again", 32'(grant), 32'h1);

    // 5: waiting requester only wins once the slice is used up
    do_reset(4'b0000, 4'b0001);
    run_to(3);
    check("t5.g0", 32'(grant), 32'h1);
    req = 4'b0011;
    while (cyc < 15) begin
      adv();
      check("t5.hold", 32'(grant), 32'h1);
    end
    adv();
    check("t5.blank", 32'(grant), 32'h0);
    run_to(19);
    check("t5.g1", 32'(grant), 32'h2);

    // 6a: reset during OWN
    do_reset(4'b0000, 4'b1011);
    run_to(20);
    check("t6.own_g", 32'(grant), 32'h2);
    check("t6.own_yr", 32'(led_in_yr), 32'h2B2);
    resetn = 1'b0;
    adv();
    check_off("t6.own_rst");
    check("t6.own_busy", 32'(busy), 32'h0);
    resetn = 1'b1;
    cyc    = -1;
    adv();
    check("t6.restart0", 32'(grant), 32'h1);

    // 6b: reset during BLANK
    run_to(17);
    check("t6.in_blank", 32'(busy), 32'h1);
    check("t6.in_blank_g", 32'(grant), 32'h0);
    resetn = 1'b0;
    adv();
    check_off("t6.blank_rst");
    check("t6.blank_busy", 32'(busy), 32'h0);
    resetn = 1'b1;
    cyc    = -1;
    adv();
    check("t6.restart1", 32'(grant), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
